// File: rtl/game_pkg.sv
// game_pkg: shared AI state encoding, LFSR tap mask and coordinate helpers
// for the enemy controller slice.
package game_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned DX_W    = COORD_W + 1;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] AI_LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPROACH = 3'd1,
        S_RETREAT  = 3'd2,
        S_ATTACK   = 3'd3,
        S_DODGE    = 3'd4,
        S_DEFEND   = 3'd5
    } ai_state_e;

    function automatic logic [DX_W-1:0] coord_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        return {a[COORD_W-1], a} - {b[COORD_W-1], b};
    endfunction

    // |d| of an 11-bit signed difference always fits 11 unsigned bits
    function automatic logic [COORD_W-1:0] dx_abs(input logic [DX_W-1:0] d);
        return d[DX_W-1] ? COORD_W'(-d) : COORD_W'(d);
    endfunction

endpackage

// File: rtl/ai_lfsr16.sv
// ai_lfsr16: 16-bit Fibonacci LFSR, one shift per i_step; reset loads SEED.
module ai_lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_step,
    output logic [15:0] o_value
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_step) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & AI_LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_value = lfsr_q;

endmodule

// File: rtl/enemy_ai_ctrl.sv
// enemy_ai_ctrl: rule-based enemy sequencer deciding once per enabled frame tick.
// Optional shield dodge is compiled in when ENEMY_AI_DEFEND_EN is defined.
module enemy_ai_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NEAR_DIST    = 160,
    parameter int unsigned FAR_DIST     = 320,
    parameter int unsigned DODGE_DIST   = 96,
    parameter int unsigned ATK_COOLDOWN = 30,
    parameter int unsigned DODGE_TICKS  = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic               i_tick,
    input  logic [COORD_W-1:0] i_player_x,
    input  logic [COORD_W-1:0] i_enemy_x,
    input  logic [COORD_W-1:0] i_goodbullet_x,
    input  logic               i_goodbullet_isE,
    input  logic               i_badbullet_isE,
    output logic               o_right,
    output logic               o_left,
    output logic               o_squat,
    output logic               o_defend,
    output logic               o_jump,
    output logic               o_attack,
    output logic [2:0]         o_ai_state
);

    localparam int unsigned CD_W   = $clog2(ATK_COOLDOWN + 1);
    localparam int unsigned HOLD_W = $clog2(DODGE_TICKS + 1);

    localparam logic [COORD_W-1:0] NEAR_L  = COORD_W'(NEAR_DIST);
    localparam logic [COORD_W-1:0] FAR_L   = COORD_W'(FAR_DIST);
    localparam logic [COORD_W-1:0] DODGE_L = COORD_W'(DODGE_DIST);
    localparam logic [CD_W-1:0]    CD_L    = CD_W'(ATK_COOLDOWN);
    localparam logic [HOLD_W-1:0]  HOLD_L  = HOLD_W'(DODGE_TICKS);

    ai_state_e          state_q, state_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               right_q, right_d, left_q, left_d, squat_q, squat_d;
    logic               jump_q, jump_d, attack_q, attack_d;
`ifdef ENEMY_AI_DEFEND_EN
    logic               defend_q, defend_d;
`endif

    logic               qual_tick;
    logic [15:0]        lfsr_value;
    logic               unused_lfsr;
    logic [DX_W-1:0]    dx, gdx;
    logic [COORD_W-1:0] adx, agx;
    logic               threat, in_band;

    assign qual_tick = i_enable & i_tick;

    ai_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_step  (qual_tick),
        .o_value (lfsr_value)
    );

`ifdef ENEMY_AI_DEFEND_EN
    assign unused_lfsr = ^lfsr_value[15:2];
`else
    assign unused_lfsr = ^lfsr_value[15:1];
`endif

    assign dx      = coord_diff(i_player_x, i_enemy_x);
    assign gdx     = coord_diff(i_goodbullet_x, i_enemy_x);
    assign adx     = dx_abs(dx);
    assign agx     = dx_abs(gdx);
    assign threat  = i_goodbullet_isE && (agx < DODGE_L);
    assign in_band = (adx >= NEAR_L) && (adx <= FAR_L);

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        hold_d   = hold_q;
        right_d  = right_q;
        left_d   = left_q;
        squat_d  = squat_q;
        jump_d   = 1'b0;
        attack_d = 1'b0;
`ifdef ENEMY_AI_DEFEND_EN
        defend_d = defend_q;
`endif
        if (!i_enable) begin
            state_d = S_IDLE;
            cd_d    = '0;
            hold_d  = '0;
            right_d = 1'b0;
            left_d  = 1'b0;
            squat_d = 1'b0;
`ifdef ENEMY_AI_DEFEND_EN
            defend_d = 1'b0;
`endif
        end else if (i_tick) begin
            cd_d = (cd_q == '0) ? '0 : cd_q - CD_W'(1);
            case (state_q)
                S_ATTACK: state_d = S_IDLE;
                // hold_q==0 here means a jump dodge: leave on the next tick
                S_DODGE, S_DEFEND: begin
                    if (hold_q > HOLD_W'(1)) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else begin
                        hold_d  = '0;
                        squat_d = 1'b0;
`ifdef ENEMY_AI_DEFEND_EN
                        defend_d = 1'b0;
`endif
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    right_d = 1'b0;
                    left_d  = 1'b0;
                    if (threat) begin
                        state_d = S_DODGE;
`ifdef ENEMY_AI_DEFEND_EN
                        if (lfsr_value[1:0] == 2'b10) begin
                            state_d  = S_DEFEND;
                            defend_d = 1'b1;
                            hold_d   = HOLD_L;
                        end else
`endif
                        if (lfsr_value[0]) begin
                            jump_d = 1'b1;
                        end else begin
                            squat_d = 1'b1;
                            hold_d  = HOLD_L;
                        end
                    end else if ((cd_q == '0) && !i_badbullet_isE && in_band) begin
                        state_d  = S_ATTACK;
                        attack_d = 1'b1;
                        cd_d     = CD_L;
                    end else if (adx > FAR_L) begin
                        state_d = S_APPROACH;
                        right_d = ~dx[DX_W-1];
                        left_d  = dx[DX_W-1];
                    end else if (adx < NEAR_L) begin
                        state_d = S_RETREAT;
                        right_d = dx[DX_W-1];
                        left_d  = ~dx[DX_W-1];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cd_q     <= '0;
            hold_q   <= '0;
            right_q  <= 1'b0;
            left_q   <= 1'b0;
            squat_q  <= 1'b0;
            jump_q   <= 1'b0;
            attack_q <= 1'b0;
`ifdef ENEMY_AI_DEFEND_EN
            defend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            hold_q   <= hold_d;
            right_q  <= right_d;
            left_q   <= left_d;
            squat_q  <= squat_d;
            jump_q   <= jump_d;
            attack_q <= attack_d;
`ifdef ENEMY_AI_DEFEND_EN
            defend_q <= defend_d;
`endif
        end
    end

    assign o_right    = right_q;
    assign o_left     = left_q;
    assign o_squat    = squat_q;
    assign o_jump     = jump_q;
    assign o_attack   = attack_q;
    assign o_ai_state = state_q;
`ifdef ENEMY_AI_DEFEND_EN
    assign o_defend   = defend_q;
`else
    assign o_defend   = 1'b0;
`endif

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// tb_enemy_ai_ctrl: randomized bench for enemy_ai_ctrl against a tick-level
// behavioural model; define ENEMY_AI_DEFEND_EN to also cover the shield dodge.
module tb_enemy_ai_ctrl;
    import game_pkg::*;

    localparam int NEAR = 160, FAR = 320, DODGE = 96, COOL = 30, HOLD = 12;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef ENEMY_AI_DEFEND_EN
    localparam bit DEFEND_EN = 1'b1;
`else
    localparam bit DEFEND_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, i_enable, i_tick, i_goodbullet_isE, i_badbullet_isE;
    logic [10:0] i_player_x, i_enemy_x, i_goodbullet_x;
    logic o_right, o_left, o_squat, o_defend, o_jump, o_attack;
    logic [2:0] o_ai_state;

    int checks = 0;
    int errors = 0;

    // model state
    ai_state_e   m_st;
    int          m_cd, m_hold;
    bit          m_r, m_l, m_sq, m_df, m_j, m_a;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    enemy_ai_ctrl #(
        .NEAR_DIST(NEAR), .FAR_DIST(FAR), .DODGE_DIST(DODGE),
        .ATK_COOLDOWN(COOL), .DODGE_TICKS(HOLD), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_tick(i_tick),
        .i_player_x(i_player_x), .i_enemy_x(i_enemy_x), .i_goodbullet_x(i_goodbullet_x),
        .i_goodbullet_isE(i_goodbullet_isE), .i_badbullet_isE(i_badbullet_isE),
        .o_right(o_right), .o_left(o_left), .o_squat(o_squat), .o_defend(o_defend),
        .o_jump(o_jump), .o_attack(o_attack), .o_ai_state(o_ai_state)
    );

    function automatic logic [8:0] dut_vec();
        return {o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_ai_state};
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_r, m_l, m_sq, m_df, m_j, m_a, m_st};
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb;
        fb = 1'b0;
        foreach (taps[i]) fb ^= v[taps[i]-1];
        return {v[14:0], fb};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_cd = 0; m_hold = 0; m_lfsr = SEED;
        m_r = 0; m_l = 0; m_sq = 0; m_df = 0; m_j = 0; m_a = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs currently applied.
    task automatic model_clock(input bit en, input bit tk);
        int dx, adx, gdist, cd_pre;
        logic [15:0] r;
        if (!en) begin
            model_reset_keep_lfsr();
            return;
        end
        m_j = 0; m_a = 0;
        if (!tk) return;
        r      = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        cd_pre = m_cd;
        m_cd   = (m_cd > 0) ? m_cd - 1 : 0;
        if (m_st == S_ATTACK) begin
            m_st = S_IDLE;
            return;
        end
        if (m_st == S_DODGE || m_st == S_DEFEND) begin
            if (m_hold > 1) m_hold--;
            else begin m_hold = 0; m_sq = 0; m_df = 0; m_st = S_IDLE; end
            return;
        end
        dx    = int'($signed(i_player_x)) - int'($signed(i_enemy_x));
        adx   = iabs(dx);
        gdist = iabs(int'($signed(i_goodbullet_x)) - int'($signed(i_enemy_x)));
        m_r = 0; m_l = 0;
        if (i_goodbullet_isE && gdist < DODGE) begin
            m_st = S_DODGE;
            if (DEFEND_EN && r[1:0] == 2'b10) begin m_st = S_DEFEND; m_df = 1; m_hold = HOLD; end
            else if (r[0]) m_j = 1;
            else begin m_sq = 1; m_hold = HOLD; end
        end else if (cd_pre == 0 && !i_badbullet_isE && adx >= NEAR && adx <= FAR) begin
            m_st = S_ATTACK; m_a = 1; m_cd = COOL;
        end else if (adx > FAR) begin
            m_st = S_APPROACH; m_r = (dx > 0); m_l = (dx < 0);
        end else if (adx < NEAR) begin
            m_st = S_RETREAT; m_r = (dx < 0); m_l = (dx >= 0);
        end else begin
            m_st = S_IDLE;
        end
    endtask

    task automatic model_reset_keep_lfsr();
        logic [15:0] keep;
        keep = m_lfsr;
        model_reset();
        m_lfsr = keep;
    endtask

    task automatic set_in(input int p, input int e, input int g, input bit gi, input bit bi);
        i_player_x = 11'(p); i_enemy_x = 11'(e); i_goodbullet_x = 11'(g);
        i_goodbullet_isE = gi; i_badbullet_isE = bi;
    endtask

    task automatic step(input bit en, input bit tk);
        i_enable = en; i_tick = tk;
        @(posedge clk);
        model_clock(en, tk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_enable = 1'b0; i_tick = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(600, 100, 110, 1, 0);
        i_enable = 1'b1; i_tick = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 9'd0)
            begin errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec(), 9'd0); end
        #1 rst_n = 1'b1;
        step(1, 0);
        checks++;
        if (dut_vec() !== model_vec())
            begin errors++; $display("FAIL reset_no_tick: got %b want %b", dut_vec(), model_vec()); end
    endtask

    task automatic test_approach();
        do_reset();
        set_in(600, 100, 0, 0, 0);
        step(1, 1);
        checks++;
        if ({o_right, o_left, o_ai_state} !== {1'b1, 1'b0, S_APPROACH})
            begin errors++; $display("FAIL approach_first: got r=%b l=%b st=%0d want r=1 l=0 st=%0d", o_right, o_left, o_ai_state, S_APPROACH); end
        for (int t = 0; t < 6; t++) begin
            step(1, t[0]);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL approach_hold: got %b want %b", dut_vec(), model_vec()); end
        end
        set_in(100, 700, 0, 0, 0);
        step(1, 1);
        checks++;
        if ({o_right, o_left} !== 2'b01 || dut_vec() !== model_vec())
            begin errors++; $display("FAIL approach_left: got %b want %b", dut_vec(), model_vec()); end
    endtask

    task automatic test_attack();
        int tick_idx, gap;
        do_reset();
        set_in(300, 100, 0, 0, 0);
        step(1, 1);
        checks++;
        if (o_attack !== 1'b1 || o_ai_state !== S_ATTACK)
            begin errors++; $display("FAIL attack_entry: got atk=%b st=%0d want atk=1 st=%0d", o_attack, o_ai_state, S_ATTACK); end
        step(1, 0);
        checks++;
        if (o_attack !== 1'b0)
            begin errors++; $display("FAIL attack_pulse_width: got %b want 0", o_attack); end
        tick_idx = 0; gap = 0;
        for (int t = 0; t < 40; t++) begin
            step(1, 1);
            tick_idx++;
            if (o_attack === 1'b1 && gap == 0) gap = tick_idx;
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL attack_cooldown_tick: got %b want %b", dut_vec(), model_vec()); end
            repeat ($urandom_range(0, 2)) begin
                step(1, 0);
                checks++;
                if (dut_vec() !== model_vec())
                    begin errors++; $display("FAIL attack_between_ticks: got %b want %b", dut_vec(), model_vec()); end
            end
        end
        checks++;
        if (gap != COOL + 1)
            begin errors++; $display("FAIL attack_gap: got %0d ticks want %0d", gap, COOL + 1); end
    endtask

    task automatic test_dodge();
        int  sq_len, jumps, squats;
        bit  in_sq;
        do_reset();
        set_in(500, 100, 150, 1, 0);
        jumps = 0; squats = 0; in_sq = 0; sq_len = 0;
        for (int t = 0; t < 300; t++) begin
            step(1, 1);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL dodge_tick: got %b want %b", dut_vec(), model_vec()); end
            if (o_jump === 1'b1) jumps++;
            if (in_sq) begin
                sq_len++;
                if (o_squat !== 1'b1) begin
                    in_sq = 0; squats++;
                    checks++;
                    if (sq_len != HOLD)
                        begin errors++; $display("FAIL squat_len: got %0d ticks want %0d", sq_len, HOLD); end
                end
            end else if (o_squat === 1'b1) begin
                in_sq = 1; sq_len = 0;
            end
            step(1, 0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL dodge_idle_cycle: got %b want %b", dut_vec(), model_vec()); end
            if (jumps >= 2 && squats >= 2) break;
        end
        checks++;
        if (jumps == 0 || squats == 0)
            begin errors++; $display("FAIL dodge_coverage: got jumps=%0d squats=%0d want both nonzero", jumps, squats); end
    endtask

    task automatic test_retreat_random();
        int qt, e, p, g;
        bit en, tk;
        do_reset();
        set_in(200, 200, 0, 0, 0);
        step(1, 1);
        checks++;
        if ({o_right, o_left, o_ai_state} !== {1'b0, 1'b1, S_RETREAT})
            begin errors++; $display("FAIL retreat_zero_dx: got r=%b l=%b st=%0d want r=0 l=1 st=%0d", o_right, o_left, o_ai_state, S_RETREAT); end
        qt = 0;
        for (int it = 0; it < 4000 && qt < 1000; it++) begin
            e = int'($urandom_range(0, 1000)) - 500;
            p = e + int'($urandom_range(0, 900)) - 450;
            g = e + int'($urandom_range(0, 300)) - 150;
            set_in(p, e, g, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            en = ($urandom_range(0, 39) != 0);
            tk = ($urandom_range(0, 1) == 1);
            if (en && tk) qt++;
            step(en, tk);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL random_model: got %b want %b", dut_vec(), model_vec()); end
            checks++;
            if ((o_right & o_left) | (o_jump & o_squat) | (o_attack & o_defend))
                begin errors++; $display("FAIL random_exclusive: got %b want no conflicting pair", dut_vec()); end
        end
    endtask

    task automatic test_disable();
        bit found;
        do_reset();
        set_in(300, 100, 0, 0, 0);
        step(1, 1);
        checks++;
        if (o_attack !== 1'b1)
            begin errors++; $display("FAIL disable_preattack: got %b want 1", o_attack); end
        set_in(300, 100, 150, 1, 0);
        found = 0;
        for (int t = 0; t < 300 && !found; t++) begin
            step(1, 1);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL disable_setup_tick: got %b want %b", dut_vec(), model_vec()); end
            if (o_squat === 1'b1) found = 1;
            else step(1, 0);
        end
        checks++;
        if (!found)
            begin errors++; $display("FAIL disable_no_squat: got none want squat hold"); end
        step(1, 1);
        step(0, 1);
        checks++;
        if (dut_vec() !== 9'd0 || model_vec() !== 9'd0)
            begin errors++; $display("FAIL disable_clear: got %b want %b", dut_vec(), 9'd0); end
        set_in(300, 100, 0, 0, 0);
        step(1, 0);
        step(1, 1);
        checks++;
        if (o_attack !== 1'b1 || dut_vec() !== model_vec())
            begin errors++; $display("FAIL reenable_cooldown: got %b want %b", dut_vec(), model_vec()); end
        // asynchronous reset in the middle of a squat hold
        set_in(300, 100, 150, 1, 0);
        found = 0;
        for (int t = 0; t < 300 && !found; t++) begin
            step(1, 1);
            if (o_squat === 1'b1) found = 1;
            else step(1, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!found || dut_vec() !== 9'd0)
            begin errors++; $display("FAIL reset_mid_hold: got %b found=%0d want %b", dut_vec(), found, 9'd0); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef ENEMY_AI_DEFEND_EN
    task automatic test_defend();
        int  len;
        bit  seen, in_df;
        do_reset();
        set_in(500, 100, 150, 1, 0);
        seen = 0; in_df = 0; len = 0;
        for (int t = 0; t < 600; t++) begin
            step(1, 1);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL defend_tick: got %b want %b", dut_vec(), model_vec()); end
            checks++;
            if (o_defend === 1'b1 && o_attack !== 1'b0)
                begin errors++; $display("FAIL defend_attack: got atk=%b want 0", o_attack); end
            if (in_df) begin
                len++;
                if (o_defend !== 1'b1) begin
                    in_df = 0; seen = 1;
                    checks++;
                    if (len != HOLD)
                        begin errors++; $display("FAIL defend_len: got %0d ticks want %0d", len, HOLD); end
                end
            end else if (o_defend === 1'b1) begin
                in_df = 1; len = 0;
            end
            step(1, 0);
            if (seen) break;
        end
        checks++;
        if (!seen)
            begin errors++; $display("FAIL defend_coverage: got no completed shield hold want one"); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_enable = 1'b0; i_tick = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_approach();
        test_attack();
        test_dodge();
        test_retreat_random();
        test_disable();
`ifdef ENEMY_AI_DEFEND_EN
        test_defend();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
